cla_seq_adder: RTL

- Multi-cycle controller that sequences one 4-bit carry-lookahead slice across a WIDTH-bit add/subtract.
- Processes one slice per clock, least-significant slice first.
- Sits in the ALU between the issue stage and writeback, trading latency for area.
- Uses valid/ready handshakes on both the operand and result sides.

---
 rtl/cla_pkg.sv | 24 ++
 rtl/cla_slice4.sv | 29 ++
 rtl/cla_seq_adder.sv | 116 +++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE = 4;

  // Number of slice passes needed to cover a full operand.
  function automatic int n_slices(input int width);
    return width / SLICE;
  endfunction

  // Slice counter width; at least one bit so the counter always exists.
  function automatic int cnt_width(input int width);
    int n;
    n = width / SLICE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla_slice4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are formed in parallel from generate/propagate terms.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract: one 4-bit CLA slice reused LSB-first across WIDTH bits.
// WIDTH must be a multiple of SLICE (4) and at least 8.
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  import cla_pkg::*;

  localparam int NS = n_slices(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_r, b_r, res, res_nx;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             c_out_r, ovf_r, zero_r;
  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  logic             last;

  cla_slice4 u_slice (
    .a    (a_r[SLICE-1:0]),
    .b    (b_r[SLICE-1:0]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_co)
  );

  assign last   = (cnt == LAST);
  // Result fills from the top so after NS passes the first slice sits at bit 0.
  assign res_nx = {sl_s, res[WIDTH-1:SLICE]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Operand shifters, carry chain, result register and flag capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          // Subtract is a + ~b + 1; c_in has no effect then.
          a_r   <= a;
          b_r   <= sub ? ~b : b;
          carry <= sub ? 1'b1 : c_in;
          cnt   <= '0;
        end
        RUN: begin
          a_r   <= a_r >> SLICE;
          b_r   <= b_r >> SLICE;
          res   <= res_nx;
          carry <= sl_co;
          if (last) begin
            // Carry into the MSB is recovered from the MSB sum bit of the last slice.
            c_out_r <= sl_co;
            ovf_r   <= (a_r[SLICE-1] ^ b_r[SLICE-1] ^ sl_s[SLICE-1]) ^ sl_co;
            zero_r  <= (res_nx == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule
